// File: rtl/slt_self_check.sv
// slt_self_check: built-in self-test sequencer for the signed set-less-than
// comparator. Drives operand pairs on A/B, waits SETTLE cycles, samples
// less_in and checks it against a signed golden compare.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle pulse that starts a run (ignored while busy)
//   A, B             registered operands to the comparator
//   less_in          comparator result (all WIDTH bits are checked)
//   busy, done       run in progress / run finished (held until next start)
//   error            sticky: at least one failure in current/last run
//   pass_count       passing vectors (saturating)
//   fail_count       failing vectors (saturating)
//   fail_a, fail_b   operands of the first failing vector
//   fail_less        less_in captured at the first failure
module slt_self_check #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_RAND = 254,
  parameter int unsigned SETTLE   = 1,
  parameter logic [31:0] SEED     = 32'hACE1_2024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] less_in,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      pass_count,
  output logic [15:0]      fail_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_less
);

  localparam int unsigned TOTAL = 2 + NUM_RAND;
  localparam int unsigned IW    = $clog2(TOTAL + 1);
  localparam int unsigned SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state;
  logic [31:0]    lfsr;
  logic [IW-1:0]  idx;
  logic [SW-1:0]  wcnt;

  // Fibonacci LFSR, taps 32,22,2,1
  logic [31:0] lfsr_next_c;
  assign lfsr_next_c = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

  // Golden result: 1 when A < B as two's-complement values
  logic [WIDTH-1:0] golden_c;
  assign golden_c = ($signed(A) < $signed(B)) ? WIDTH'(1) : WIDTH'(0);

  // Sequencer, operand registers and result bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= 32'd0;
      idx        <= '0;
      wcnt       <= '0;
      A          <= '0;
      B          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      pass_count <= 16'd0;
      fail_count <= 16'd0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_less  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            pass_count <= 16'd0;
            fail_count <= 16'd0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_less  <= '0;
            lfsr       <= SEED;
            idx        <= '0;
          end
        end

        DRIVE: begin
          // Two fixed vectors first, then LFSR halves; LFSR steps per random vector
          if (idx == IW'(0)) begin
            A <= WIDTH'(4);
            B <= WIDTH'(5);
          end else if (idx == IW'(1)) begin
            A <= WIDTH'(4);
            B <= WIDTH'(1);
          end else begin
            A    <= WIDTH'(lfsr[31:16]);
            B    <= WIDTH'(lfsr[15:0]);
            lfsr <= lfsr_next_c;
          end
          wcnt  <= '0;
          state <= (SETTLE > 0) ? WAIT : CHECK;
        end

        WAIT: begin
          if (wcnt == SW'(SETTLE - 1)) begin
            state <= CHECK;
          end else begin
            wcnt <= wcnt + SW'(1);
          end
        end

        CHECK: begin
          if (less_in == golden_c) begin
            if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
          end else begin
            if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
            error <= 1'b1;
            // fail_count never returns to zero once incremented, so this marks the first failure
            if (fail_count == 16'd0) begin
              fail_a    <= A;
              fail_b    <= B;
              fail_less <= less_in;
            end
          end
          if (idx == IW'(TOTAL - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx   <= idx + IW'(1);
            state <= DRIVE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slt_self_check.sv
// Bench for slt_self_check: three instances (default, two-vector, zero-settle)
// each driven by a selectable comparator model; run outcomes are compared
// against a vector-list reference built from the LFSR rules.
module tb_slt_self_check;

  localparam logic [31:0] SEED = 32'hACE1_2024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Per-instance parameters: 0 default, 1 NUM_RAND=0, 2 SETTLE=0
  int nr_p[3] = '{254, 0, 254};
  int st_p[3] = '{1, 1, 0};

  logic [15:0] a_o[3], b_o[3], lin[3], pc[3], fc[3], fa[3], fb[3], fl[3];
  logic        bsy[3], dn[3], er[3], st[3];
  int          mode[3];

  int n_vec = 0;
  int n_mis = 0;

  // Comparator models: 0 ideal signed, 1 stuck at 1, 2 unsigned, 3 0101 on true
  function automatic logic [15:0] cmp_model(input int md, input logic [15:0] a, input logic [15:0] b);
    case (md)
      0:       return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      1:       return 16'd1;
      2:       return (a < b) ? 16'd1 : 16'd0;
      3:       return ($signed(a) < $signed(b)) ? 16'h0101 : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cmp
    assign lin[g] = cmp_model(mode[g], a_o[g], b_o[g]);
  end

  slt_self_check u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .A(a_o[0]), .B(b_o[0]), .less_in(lin[0]),
    .busy(bsy[0]), .done(dn[0]), .error(er[0]), .pass_count(pc[0]), .fail_count(fc[0]),
    .fail_a(fa[0]), .fail_b(fb[0]), .fail_less(fl[0]));

  slt_self_check #(.NUM_RAND(0), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .A(a_o[1]), .B(b_o[1]), .less_in(lin[1]),
    .busy(bsy[1]), .done(dn[1]), .error(er[1]), .pass_count(pc[1]), .fail_count(fc[1]),
    .fail_a(fa[1]), .fail_b(fb[1]), .fail_less(fl[1]));

  slt_self_check #(.NUM_RAND(254), .SETTLE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .A(a_o[2]), .B(b_o[2]), .less_in(lin[2]),
    .busy(bsy[2]), .done(dn[2]), .error(er[2]), .pass_count(pc[2]), .fail_count(fc[2]),
    .fail_a(fa[2]), .fail_b(fb[2]), .fail_less(fl[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: expected vector list and run outcome from plain arithmetic
  logic [15:0] ra[$], rb[$];
  int          rp, rf;
  logic [15:0] rfa, rfb, rfl;

  function automatic int sval(input logic [15:0] x);
    return (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
  endfunction

  task automatic ref_run(input int nr, input int md);
    bit [31:0]   s;
    logic [15:0] a, b, l, g;
    s = SEED;
    ra.delete(); rb.delete();
    rp = 0; rf = 0; rfa = 0; rfb = 0; rfl = 0;
    for (int k = 0; k < 2 + nr; k++) begin
      if (k == 0) begin a = 16'd4; b = 16'd5; end
      else if (k == 1) begin a = 16'd4; b = 16'd1; end
      else begin
        a = s[31:16];
        b = s[15:0];
        s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
      end
      l = cmp_model(md, a, b);
      g = (sval(a) < sval(b)) ? 16'd1 : 16'd0;
      if (l == g) rp++;
      else begin
        if (rf == 0) begin rfa = a; rfb = b; rfl = l; end
        rf++;
      end
      ra.push_back(a);
      rb.push_back(b);
    end
  endtask

  typedef struct {
    int inst;   // which instance
    int md;     // comparator model
    int inj;    // cycle of an extra start pulse (0 = none)
    int cyc;    // expected cycles from start edge to done
    int pass;   // expected pass_count (-1 = from reference)
    int fail;   // expected fail_count (-1 = from reference)
  } run_t;

  run_t tbl[7];

  task automatic do_run(input run_t r);
    int  i, per, total;
    bit  got;
    i     = r.inst;
    per   = st_p[i] + 2;
    total = 2 + nr_p[i];
    ref_run(nr_p[i], r.md);
    mode[i] = r.md;
    @(negedge clk);
    st[i] = 1'b1;
    @(posedge clk);
    #1 st[i] = 1'b0;
    chk("busy_rise", 32'(bsy[i]), 32'd1);
    chk("done_clear", 32'(dn[i]), 32'd0);
    got = 1'b0;
    for (int c = 1; c <= r.cyc + 20; c++) begin
      @(posedge clk);
      #1;
      if (st[i]) st[i] = 1'b0;
      if (r.inj != 0 && c == r.inj) st[i] = 1'b1;
      if ((c - 1) % per == 0 && (c - 1) / per < total) begin
        chk("vec_a", 32'(a_o[i]), 32'(ra[(c - 1) / per]));
        chk("vec_b", 32'(b_o[i]), 32'(rb[(c - 1) / per]));
      end
      if (dn[i]) begin
        chk("run_len", 32'(c), 32'(r.cyc));
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_mis++;
      $display("FAIL done_timeout: inst %0d no done within %0d cycles", i, r.cyc + 20);
    end
    chk("pass_count", 32'(pc[i]), (r.pass >= 0) ? 32'(r.pass) : 32'(rp));
    chk("fail_count", 32'(fc[i]), (r.fail >= 0) ? 32'(r.fail) : 32'(rf));
    chk("ref_pass", 32'(pc[i]), 32'(rp));
    chk("error", 32'(er[i]), (rf > 0) ? 32'd1 : 32'd0);
    chk("fail_a", 32'(fa[i]), 32'(rfa));
    chk("fail_b", 32'(fb[i]), 32'(rfb));
    chk("fail_less", 32'(fl[i]), 32'(rfl));
    chk("busy_fall", 32'(bsy[i]), 32'd0);
    chk("hold_a", 32'(a_o[i]), 32'(ra[total - 1]));
    chk("hold_b", 32'(b_o[i]), 32'(rb[total - 1]));
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_a"}, 32'(a_o[i]), 32'd0);
    chk({tag, "_b"}, 32'(b_o[i]), 32'd0);
    chk({tag, "_busy"}, 32'(bsy[i]), 32'd0);
    chk({tag, "_done"}, 32'(dn[i]), 32'd0);
    chk({tag, "_error"}, 32'(er[i]), 32'd0);
    chk({tag, "_pass"}, 32'(pc[i]), 32'd0);
    chk({tag, "_fail"}, 32'(fc[i]), 32'd0);
    chk({tag, "_fa"}, 32'(fa[i]), 32'd0);
    chk({tag, "_fb"}, 32'(fb[i]), 32'd0);
    chk({tag, "_fl"}, 32'(fl[i]), 32'd0);
  endtask

  initial begin
    tbl[0] = '{inst: 1, md: 0, inj: 0,   cyc: 6,   pass: 2,   fail: 0};
    tbl[1] = '{inst: 1, md: 1, inj: 0,   cyc: 6,   pass: 1,   fail: 1};
    tbl[2] = '{inst: 0, md: 0, inj: 0,   cyc: 768, pass: 256, fail: 0};
    tbl[3] = '{inst: 0, md: 2, inj: 0,   cyc: 768, pass: -1,  fail: -1};
    tbl[4] = '{inst: 0, md: 3, inj: 0,   cyc: 768, pass: -1,  fail: -1};
    tbl[5] = '{inst: 0, md: 0, inj: 100, cyc: 768, pass: 256, fail: 0};
    tbl[6] = '{inst: 2, md: 0, inj: 0,   cyc: 512, pass: 256, fail: 0};

    for (int i = 0; i < 3; i++) begin
      st[i]   = 1'b0;
      mode[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero(0, "reset");
    chk_zero(1, "reset1");

    for (int t = 0; t < 6; t++) begin
      do_run(tbl[t]);
      if (t == 1) begin
        // Stuck-at-1 model: vector 0 (4<5) passes, vector 1 (4<1) is the first failure
        chk("stuck_fa", 32'(fa[1]), 32'd4);
        chk("stuck_fb", 32'(fb[1]), 32'd1);
        chk("stuck_fl", 32'(fl[1]), 32'd1);
        chk("stuck_err", 32'(er[1]), 32'd1);
      end
      if (t == 4) begin
        // 0101 model: the very first vector (4<5 true) already fails on upper bits
        chk("upper_fl", 32'(fl[0]), 32'h0101);
        chk("upper_fa", 32'(fa[0]), 32'd4);
      end
      if (t == 3) chk("unsigned_total", 32'(pc[0]) + 32'(fc[0]), 32'd256);
    end

    // Reset asserted mid-run clears everything immediately and leaves the block idle
    mode[0] = 2;
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    chk("midrun_busy", 32'(bsy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero(0, "midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_zero(0, "idle_after_rst");

    do_run(tbl[6]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/slt_self_check.md
# slt_self_check

Hardware self-check sequencer for the 16-bit CPU's set-less-than comparator (SLTI). It is the driving and checking end of the comparator interface. It generates operand pairs on `A`/`B`, waits for the comparator to settle, and samples its `Less` result. Each sample is checked against a signed golden compare, and passes, failures and the first failing vector are recorded. It sits beside the ALU as a built-in self-test block and is started by the test controller or a bench.

## Interface
- `WIDTH`, 16: operand and result width.
- `NUM_RAND`, 254: number of pseudo-random vectors run after the two fixed vectors.
- `SETTLE`, 1: wait cycles between driving operands and sampling `less_in` (0 allowed).
- `SEED`, 32'hACE1_2024: LFSR seed loaded on `start`; must be nonzero.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse that begins a run; ignored while `busy`=1.
- `A`  out  WIDTH: operand A to the comparator (registered).
- `B`  out  WIDTH: operand B to the comparator (registered).
- `less_in`  in  WIDTH: comparator `Less` result.
- `busy`  out  1: run in progress.
- `done`  out  1: run finished; held until the next `start` or reset.
- `error`  out  1: at least one failure in the current or last run (sticky).
- `pass_count`  out  16: vectors that passed; saturates at 16'hFFFF.
- `fail_count`  out  16: vectors that failed; saturates at 16'hFFFF.
- `fail_a`, `fail_b`  out  WIDTH: operands of the first failing vector.
- `fail_less`  out  WIDTH: `less_in` value captured at the first failure.

## Operation
- States:
  - IDLE: reset state.
  - DRIVE: present the vector on `A`/`B`.
  - WAIT: count `SETTLE` cycles.
  - CHECK: sample `less_in` and compare.
  - DONE: run complete.
- Transitions:
  - IDLE or DONE with `start`=1 → DRIVE.
  - DRIVE → WAIT if `SETTLE`>0, else → CHECK.
  - WAIT → CHECK after exactly `SETTLE` cycles.
  - CHECK → DRIVE if vectors remain, else → DONE.
- On `start`:
  - clear `pass_count`, `fail_count`, `error`, `fail_a`, `fail_b`, `fail_less` and `done`;
  - load the LFSR with `SEED` and set the vector index to 0.
- Vector sequence, total `2+NUM_RAND`:
  - index 0: A=16'd4, B=16'd5;
  - index 1: A=16'd4, B=16'd1;
  - index ≥2: A=lfsr[31:16], B=lfsr[15:0], with the LFSR stepped once after each random vector's DRIVE.
- LFSR: 32-bit Fibonacci, taps 32,22,2,1. It shifts left and feeds the XOR of bits 31,21,1,0 into bit 0.
- Golden result:
  - 16'd1 if $signed(A) < $signed(B), else 16'd0.
  - Every bit of `less_in` is compared. A nonzero upper bit or a wrong LSB is a failure.
- In CHECK:
  - a match increments `pass_count`;
  - a mismatch increments `fail_count` and sets `error`;
  - if this is the first failure, capture `fail_a`, `fail_b` and `fail_less`.
- `A`/`B` hold their value from DRIVE through CHECK. They hold the last vector in DONE.
- Boundary cases:
  - A=B gives 0.
  - A=16'h8000, B=16'h7FFF gives 1 (signed).
  - A=16'h7FFF, B=16'h8000 gives 0.
  - A counter at 16'hFFFF stays there.
- Reset mid-run: all state and outputs return to reset values immediately. No partial results are retained.

## Timing
- Reset values:
  - state IDLE;
  - `A`=`B`=0;
  - `busy`=`done`=`error`=0;
  - all counts and capture registers 0.
- `start` sampled high at edge N: `busy`=1 and the first vector is on `A`/`B` after edge N+1.
- Each vector takes `SETTLE`+2 cycles. `less_in` is sampled at the edge ending CHECK, i.e. `SETTLE`+1 cycles after `A`/`B` change.
- Run length: (2+`NUM_RAND`)·(`SETTLE`+2) cycles from first DRIVE to DONE.
- On entering DONE: `busy` falls and `done` rises in the same cycle. Counters are final in that cycle.
- `start` in DONE restarts in the next cycle (DONE → DRIVE). `done` falls on that edge.
- `start` while `busy`=1 has no effect.

## Test plan
- Reset, then `start` with `NUM_RAND`=0, `SETTLE`=1, and an ideal signed comparator model:
  - A/B show 4/5, then 4/1;
  - sampled results are 1, then 0;
  - `done`=1 after 6 cycles, `pass_count`=2, `fail_count`=0, `error`=0.
- Default parameters with an ideal model → `pass_count`=256, `fail_count`=0, `done`=1 after 768 cycles.
- Faulty model forcing `less_in`=16'd1 always → vector 0 passes and vector 1 fails:
  - `fail_a`=4, `fail_b`=1, `fail_less`=1, `error`=1.
- Unsigned-compare model, random vectors → failures only where operand signs differ.
  - `fail_a`/`fail_b` hold the first such pair.
  - `pass_count`+`fail_count`=256.
- Model returning 16'h0101 on a true compare → a true result still counts as a failure (upper bits are checked).
- Control and reset cases:
  - `start` pulsed mid-run is ignored; totals are unchanged.
  - `rst_n` asserted mid-run sets all outputs to 0 and the state to IDLE.
  - A fresh `start` with `SETTLE`=0 gives `done` after 512 cycles.
